// File: rtl/cnn_csa_pkg.sv
// rtl/cnn_csa_pkg.sv - shared widths and FSM encoding for the CSA/psum datapath
package cnn_csa_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational unsigned saturating adder with overflow flag
module sat_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  // One extra bit holds the carry; any carry means the result clamps to all-ones.
  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[ACC_W];
  assign sum  = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - windowed saturating accumulator for CSA partial sums
module psum_accumulator
  import cnn_csa_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] sum_ext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_eff;
  logic             ovf;
  logic             add_ovf;
  logic             accept;

  assign sum_ext = ACC_W'(in_sum);
  assign cnt_nxt = cnt + CNT_W'(1);
  // A zero-length window would never terminate, so it runs as a single beat.
  assign len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;

  assign in_ready = rst_n && (state != ST_DONE);
  assign accept   = in_valid && in_ready;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (sum_ext),
    .sum (acc_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc   <= sum_ext;
            cnt   <= CNT_W'(1);
            len_q <= len_eff;
            ovf   <= 1'b0;
            state <= (len_eff == CNT_W'(1)) ? ST_DONE : ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_nxt;
            ovf <= ovf | add_ovf;
            if (cnt_nxt == len_q) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state == ST_DONE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;
  assign out_cnt   = cnt;

endmodule
